// File: rtl/qadd_pkg.sv
// rtl/qadd_pkg.sv - shared constants and width/bound helpers for qadd_pipe
package qadd_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // One guard bit above the wider operand keeps a+b and a-b exact.
    function automatic int full_width(input int aw, input int bw);
        return ((aw > bw) ? aw : bw) + 1;
    endfunction

    function automatic longint bound_hi(input int ow);
        return (longint'(1) <<< (ow - 1)) - longint'(1);
    endfunction

    function automatic longint bound_lo(input int ow);
        return -(longint'(1) <<< (ow - 1));
    endfunction

endpackage

// File: rtl/qadd_sat.sv
// rtl/qadd_sat.sv - combinational exact-sum to output-width converter
module qadd_sat
    import qadd_pkg::*;
#(
    parameter int FULLW    = 17,
    parameter int OWIDTH   = 17,
    parameter int SATURATE = 1
) (
    input  logic signed [FULLW-1:0]  sum_full,
    output logic signed [OWIDTH-1:0] sum_out,
    output logic                     ovf
);

    generate
        if (OWIDTH >= FULLW) begin : g_extend
            assign sum_out = OWIDTH'(sum_full);
            assign ovf     = 1'b0;
        end else begin : g_narrow
            localparam logic signed [FULLW-1:0] HI = FULLW'(bound_hi(OWIDTH));
            localparam logic signed [FULLW-1:0] LO = FULLW'(bound_lo(OWIDTH));

            logic over_hi;
            logic under_lo;

            assign over_hi = (sum_full > HI);
            assign under_lo = (sum_full < LO);
            assign ovf     = over_hi | under_lo;

            if (SATURATE != 0) begin : g_sat
                always_comb begin
                    sum_out = sum_full[OWIDTH-1:0];
                    if (over_hi) begin
                        sum_out = HI[OWIDTH-1:0];
                    end else if (under_lo) begin
                        sum_out = LO[OWIDTH-1:0];
                    end
                end
            end else begin : g_wrap
                assign sum_out = sum_full[OWIDTH-1:0];
            end
        end
    endgenerate

endmodule

// File: rtl/qadd_pipe.sv
// rtl/qadd_pipe.sv - pipelined signed fixed-point add/sub with saturate/wrap
module qadd_pipe
    import qadd_pkg::*;
#(
    parameter int AWIDTH   = 16,
    parameter int BWIDTH   = 16,
    parameter int OWIDTH   = 17,
    parameter int LATENCY  = 2,
    parameter int SATURATE = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_ce,
    input  logic                     i_valid,
    input  logic                     i_sub,
    input  logic signed [AWIDTH-1:0] i_a,
    input  logic signed [BWIDTH-1:0] i_b,
    input  logic                     i_ovf_clr,
    output logic                     o_valid,
    output logic signed [OWIDTH-1:0] o_sum,
    output logic                     o_ovf,
    output logic                     o_ovf_sticky
);

    localparam int FULLW = full_width(AWIDTH, BWIDTH);

    logic signed [FULLW-1:0]  a_ext;
    logic signed [FULLW-1:0]  b_ext;
    logic signed [FULLW-1:0]  exact_sum;
    logic signed [FULLW-1:0]  final_sum;
    logic                     final_valid;
    logic signed [OWIDTH-1:0] sat_sum;
    logic                     sat_ovf;

    assign a_ext     = FULLW'(i_a);
    assign b_ext     = FULLW'(i_b);
    assign exact_sum = (i_sub == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);

    // Stages before the output register carry the exact FULLW sum only.
    generate
        if (LATENCY == 1) begin : g_direct
            assign final_sum   = exact_sum;
            assign final_valid = i_valid;
        end else begin : g_pipe
            logic signed [FULLW-1:0] pipe_sum [LATENCY-1];
            logic [LATENCY-2:0]      pipe_valid;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    pipe_valid <= '0;
                    for (int s = 0; s < LATENCY - 1; s++) begin
                        pipe_sum[s] <= '0;
                    end
                end else if (i_ce) begin
                    pipe_sum[0]   <= exact_sum;
                    pipe_valid[0] <= i_valid;
                    for (int s = 1; s < LATENCY - 1; s++) begin
                        pipe_sum[s]   <= pipe_sum[s-1];
                        pipe_valid[s] <= pipe_valid[s-1];
                    end
                end
            end

            assign final_sum   = pipe_sum[LATENCY-2];
            assign final_valid = pipe_valid[LATENCY-2];
        end
    endgenerate

    qadd_sat #(
        .FULLW    (FULLW),
        .OWIDTH   (OWIDTH),
        .SATURATE (SATURATE)
    ) u_sat (
        .sum_full (final_sum),
        .sum_out  (sat_sum),
        .ovf      (sat_ovf)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_ovf   <= 1'b0;
        end else if (i_ce) begin
            o_valid <= final_valid;
            o_sum   <= sat_sum;
            o_ovf   <= final_valid & sat_ovf;
        end
    end

    // A sample leaving the output register sets the flag; set beats clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_ovf_sticky <= 1'b0;
        end else if (i_ce && o_valid && o_ovf) begin
            o_ovf_sticky <= 1'b1;
        end else if (i_ovf_clr) begin
            o_ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qadd_pipe.sv
// tb/tb_qadd_pipe.sv - directed self-checking bench for qadd_pipe
module tb_qadd_pipe;

    logic clk = 1'b0;
    logic rst_n, ce, valid, sub, ovf_clr;
    logic signed [15:0] a, b;

    logic               v0, v1, v2;
    logic signed [16:0] s0;
    logic signed [15:0] s1, s2;
    logic               f0, f1, f2;
    logic               st0, st1, st2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // u0: full width; u1: narrow saturating; u2: narrow wrapping
    qadd_pipe #(.OWIDTH(17), .SATURATE(1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_valid(valid), .i_sub(sub),
        .i_a(a), .i_b(b), .i_ovf_clr(ovf_clr),
        .o_valid(v0), .o_sum(s0), .o_ovf(f0), .o_ovf_sticky(st0));

    qadd_pipe #(.OWIDTH(16), .SATURATE(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_valid(valid), .i_sub(sub),
        .i_a(a), .i_b(b), .i_ovf_clr(ovf_clr),
        .o_valid(v1), .o_sum(s1), .o_ovf(f1), .o_ovf_sticky(st1));

    qadd_pipe #(.OWIDTH(16), .SATURATE(0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_valid(valid), .i_sub(sub),
        .i_a(a), .i_b(b), .i_ovf_clr(ovf_clr),
        .o_valid(v2), .o_sum(s2), .o_ovf(f2), .o_ovf_sticky(st2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vl, input logic sb, input int av, input int bv);
        valid = vl;
        sub   = sb;
        a     = 16'(av);
        b     = 16'(bv);
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_next;

        rst_n = 1'b0; ce = 1'b1; ovf_clr = 1'b0;
        drive(1'b0, 1'b0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        check("rst_valid", 64'(v0), 64'(0));
        check("rst_sum", 64'(s0), 64'(0));
        check("rst_ovf", 64'(f0), 64'(0));
        check("rst_sticky", 64'(st1), 64'(0));

        // basic add then sub, two-edge latency
        drive(1'b1, 1'b0, 20, 3);
        step();
        check("lat_not_early", 64'(v0), 64'(0));
        drive(1'b1, 1'b1, 20, 3);
        step();
        check("add_valid", 64'(v0), 64'(1));
        check("add_sum", 64'(s0), 64'(23));
        check("add_ovf", 64'(f0), 64'(0));
        drive(1'b0, 1'b0, 0, 0);
        step();
        check("sub_valid", 64'(v0), 64'(1));
        check("sub_sum", 64'(s0), 64'(17));
        step();
        check("drain_valid", 64'(v0), 64'(0));

        // full-width extremes
        drive(1'b1, 1'b0, 32767, 32767);
        step();
        drive(1'b1, 1'b1, -32768, 32767);
        step();
        check("fw_max_sum", 64'(s0), 64'(65534));
        check("fw_max_ovf", 64'(f0), 64'(0));
        check("sat_fw_max_sum", 64'(s1), 64'(32767));
        check("sat_fw_max_ovf", 64'(f1), 64'(1));
        check("wrap_fw_max_sum", 64'(s2), -64'sd2);
        check("wrap_fw_max_ovf", 64'(f2), 64'(1));
        drive(1'b0, 1'b0, 0, 0);
        step();
        check("fw_min_sum", 64'(s0), -64'sd65535);
        check("fw_min_ovf", 64'(f0), 64'(0));
        check("sat_fw_min_sum", 64'(s1), -64'sd32768);
        check("wrap_fw_min_sum", 64'(s2), 64'(1));
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("sticky_cleared", 64'(st1), 64'(0));

        // saturate vs wrap at 16 bits, then set-beats-clear
        drive(1'b1, 1'b0, 32767, 1);
        step();
        drive(1'b1, 1'b1, -32768, 1);
        step();
        check("sat_hi_sum", 64'(s1), 64'(32767));
        check("sat_hi_ovf", 64'(f1), 64'(1));
        check("wrap_hi_sum", 64'(s2), -64'sd32768);
        check("wrap_hi_ovf", 64'(f2), 64'(1));
        check("fw_hi_sum", 64'(s0), 64'(32768));
        check("sticky_not_yet", 64'(st1), 64'(0));
        drive(1'b0, 1'b0, 0, 0);
        ovf_clr = 1'b1;
        step();
        check("sat_lo_sum", 64'(s1), -64'sd32768);
        check("sat_lo_ovf", 64'(f1), 64'(1));
        check("wrap_lo_sum", 64'(s2), 64'(32767));
        check("sticky_set_wins", 64'(st1), 64'(1));
        check("sticky_full_width", 64'(st0), 64'(0));
        step();
        check("sticky_still_set", 64'(st1), 64'(1));
        step();
        ovf_clr = 1'b0;
        check("sticky_late_clear", 64'(st1), 64'(0));

        // stall: ce low for 3 cycles after the third input
        exp_next = 1;
        for (int c = 0; c < 14; c++) begin
            if (c < 3) begin
                ce = 1'b1; drive(1'b1, 1'b0, c + 1, 0);
            end else if (c < 6) begin
                ce = 1'b0; drive(1'b1, 1'b0, 99, 0);
            end else if (c < 9) begin
                ce = 1'b1; drive(1'b1, 1'b0, c - 2, 0);
            end else begin
                ce = 1'b1; drive(1'b0, 1'b0, 0, 0);
            end
            step();
            if (c >= 3 && c < 6) begin
                check("stall_hold_sum", 64'(s0), 64'(2));
                check("stall_hold_valid", 64'(v0), 64'(1));
            end else if (v0) begin
                check("stall_seq", 64'(s0), 64'(exp_next));
                exp_next++;
            end
        end
        check("stall_count", 64'(exp_next), 64'(7));

        // reset with two samples in flight, ce low to show reset wins
        drive(1'b1, 1'b0, 10, 0);
        step();
        drive(1'b1, 1'b0, 11, 0);
        step();
        check("pre_rst_sum", 64'(s0), 64'(10));
        rst_n = 1'b0; ce = 1'b0;
        drive(1'b1, 1'b0, 12, 0);
        step();
        check("mid_rst_valid", 64'(v0), 64'(0));
        check("mid_rst_sum", 64'(s0), 64'(0));
        rst_n = 1'b1; ce = 1'b1;
        drive(1'b0, 1'b0, 0, 0);
        step();
        check("post_rst_valid1", 64'(v0), 64'(0));
        step();
        check("post_rst_valid2", 64'(v0), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
